// File: rtl/saradc_seq.sv
// saradc_seq: multi-channel successive-approximation sequencer for the SAR front-end.
// Scans enabled channels round-robin, averages 2^avg_log2 conversions per result
// and removes a calibrated comparator offset with saturation to the code range.
module saradc_seq #(
    parameter  int RES        = 10,
    parameter  int NCH        = 4,
    parameter  int SAMPLE_CYC = 4,
    localparam int CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           en,
    input  logic           cal,
    input  logic [NCH-1:0] ch_mask,
    input  logic [1:0]     avg_log2,
    input  logic           cmp_i,
    output logic           sample_o,
    output logic           cal_o,
    output logic [CW-1:0]  ch_sel,
    output logic [RES-1:0] dac_code,
    output logic [RES-1:0] result,
    output logic [CW-1:0]  result_ch,
    output logic           valid,
    output logic           cal_done,
    output logic [RES:0]   offset,
    output logic           busy
);

    typedef enum logic [2:0] {IDLE, SAMPLE, CONV, ACC, DONE} state_t;

    localparam int BW = (RES > 1) ? $clog2(RES) : 1;
    localparam int SW = $clog2(SAMPLE_CYC + 1);
    localparam int AW = RES + 3;
    localparam logic [RES:0]   MID  = {2'b01, {(RES - 1){1'b0}}};
    localparam logic [RES-1:0] FULL = '1;

    state_t          state;
    logic [BW-1:0]   bit_idx;
    logic            phase;      // 0 = set trial bit, 1 = decide
    logic [SW-1:0]   samp_cnt;
    logic [AW-1:0]   acc;
    logic [3:0]      cnt;
    logic [1:0]      avg_q;
    logic            is_cal;

    logic [RES-1:0]  avg;
    logic [RES:0]    offset_new;
    logic [RES+1:0]  diff;
    logic [RES-1:0]  corrected;
    logic            cnt_last;
    logic            start;
    logic [CW-1:0]   start_ch;

    // Lowest-numbered enabled channel.
    function automatic logic [CW-1:0] lowest(input logic [NCH-1:0] m);
        lowest = '0;
        for (int i = NCH - 1; i >= 0; i--)
            if (m[i]) lowest = CW'(i);
    endfunction

    // Next enabled channel above cur, wrapping to the lowest one.
    function automatic logic [CW-1:0] next_ch(input logic [NCH-1:0] m, input logic [CW-1:0] cur);
        logic found;
        next_ch = lowest(m);
        found   = 1'b0;
        for (int i = 0; i < NCH; i++)
            if (!found && m[i] && i > int'(cur)) begin
                next_ch = CW'(i);
                found   = 1'b1;
            end
    endfunction

    assign avg        = RES'(acc >> avg_q);
    assign offset_new = {1'b0, avg} - MID;
    assign diff       = {2'b00, avg} - {offset[RES], offset};
    assign cnt_last   = ((cnt + 4'd1) == (4'd1 << avg_q));
    assign start      = en && (cal || (|ch_mask)) && (state == IDLE || state == DONE);
    assign start_ch   = (state == IDLE) ? lowest(ch_mask) : next_ch(ch_mask, ch_sel);

    // Offset-corrected average clamped to [0, 2^RES-1].
    always_comb begin
        // NOTE: assign a default first so every path drives the signal; no latch is inferred.
        corrected = diff[RES-1:0];
        if (diff[RES+1])
            corrected = '0;
        else if (diff[RES])
            corrected = FULL;
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            bit_idx   <= '0;
            phase     <= 1'b0;
            samp_cnt  <= '0;
            acc       <= '0;
            cnt       <= '0;
            avg_q     <= '0;
            is_cal    <= 1'b0;
            sample_o  <= 1'b0;
            cal_o     <= 1'b0;
            ch_sel    <= '0;
            dac_code  <= '0;
            result    <= '0;
            result_ch <= '0;
            valid     <= 1'b0;
            cal_done  <= 1'b0;
            offset    <= '0;
            busy      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments everywhere here, so every branch reads pre-edge state.
            valid    <= 1'b0;
            cal_done <= 1'b0;
            if (state != IDLE && !en) begin
                state    <= IDLE;
                busy     <= 1'b0;
                sample_o <= 1'b0;
                cal_o    <= 1'b0;
                dac_code <= '0;
            end else begin
                case (state)
                    IDLE: ;
                    SAMPLE: begin
                        if (samp_cnt == SW'(SAMPLE_CYC - 1)) begin
                            state    <= CONV;
                            sample_o <= 1'b0;
                            bit_idx  <= BW'(RES - 1);
                            phase    <= 1'b0;
                        end else begin
                            samp_cnt <= samp_cnt + 1'b1;
                        end
                    end
                    CONV: begin
                        if (!phase) begin
                            dac_code[bit_idx] <= 1'b1;
                            phase             <= 1'b1;
                        end else begin
                            if (!cmp_i) dac_code[bit_idx] <= 1'b0;
                            phase <= 1'b0;
                            if (bit_idx == '0) state <= ACC;
                            else               bit_idx <= bit_idx - 1'b1;
                        end
                    end
                    ACC: begin
                        acc      <= acc + AW'(dac_code);
                        cnt      <= cnt + 4'd1;
                        dac_code <= '0;
                        if (cnt_last) begin
                            state <= DONE;
                        end else begin
                            state    <= SAMPLE;
                            sample_o <= 1'b1;
                            samp_cnt <= '0;
                        end
                    end
                    DONE: begin
                        if (is_cal) begin
                            offset   <= offset_new;
                            cal_done <= 1'b1;
                        end else begin
                            result    <= corrected;
                            result_ch <= ch_sel;
                            valid     <= 1'b1;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                        cal_o <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
                // Group start from IDLE, or straight from DONE; overrides the DONE exit above.
                if (start) begin
                    state    <= SAMPLE;
                    busy     <= 1'b1;
                    sample_o <= 1'b1;
                    samp_cnt <= '0;
                    acc      <= '0;
                    cnt      <= '0;
                    avg_q    <= avg_log2;
                    is_cal   <= cal;
                    cal_o    <= cal;
                    if (!cal) ch_sel <= start_ch;
                end
            end
        end
    end

endmodule
